countdown_display_ctrl: RTL
===========================

// Module: countdown_display_ctrl
// PURPOSE
// Downstream consumer of the one-second countdown: samples the 32-bit countdown value after each
// second tick, clamps it to 0..9999, and converts it to 4-digit BCD with a sequential
// shift-add-3 (double-dabble) FSM. It drives active-low 7-segment HEX digits and raises a
// sticky time-up flag for the game FSM when the countdown reaches zero or goes negative.
// PARAMETERS
// CNT_W     32    width of counter_in (treated as two's-complement signed)
// BIN_W     14    binary width converted (covers 0..9999)
// MAX_VAL   9999  clamp ceiling applied before conversion
// BLANK_LZ  1     1 = blank leading-zero digits (digit 0 always shown); 0 = show all digits
// PORTS
// Clk            in   1      system clock
// Reset          in   1      synchronous, active-high reset
// sec            in   1      one-cycle second tick from the countdown stage
// counter_in     in   CNT_W  countdown value; updates 1 cycle after sec
// bcd_out        out  16     {d3,d2,d1,d0} BCD of clamped value
// bcd_valid      out  1      1-cycle pulse when bcd_out/hex*/time_up update
// busy           out  1      high while a conversion is in progress
// time_up        out  1      level: last captured value <= 0 (signed)
// time_up_pulse  out  1      1-cycle pulse on the 0->1 transition of time_up
// hex0..hex3     out  7 each active-low segments {g,f,e,d,c,b,a}; hex0 = ones digit
// BEHAVIOUR
// - Clk is the only clock; Reset is synchronous, active-high, and overrides everything.
// - Reset values: bcd_out=16'h0000, bcd_valid=0, busy=0, time_up=0, time_up_pulse=0,
//   hex0..hex3=7'h7F (all segments off), pending=0, FSM=IDLE.
// - Trigger: sec is registered once (sec_d). sec_d==1, or the first cycle after Reset deasserts
//   (auto-init), starts a conversion. Sampling at sec_d aligns with counter_in having updated.
// - FSM states IDLE -> CAPTURE -> SHIFT -> DONE -> IDLE (or -> CAPTURE when pending).
//   IDLE: on trigger, go to CAPTURE; busy=1 from CAPTURE through DONE.
//   CAPTURE (1 cycle): sample counter_in, clamp: signed<0 -> 0; >MAX_VAL -> MAX_VAL; else
//     value. Record neg_or_zero = (signed counter_in <= 0). Load the BIN_W-bit binary value and
//     clear the 16-bit BCD scratch.
//   SHIFT (exactly BIN_W cycles): each cycle, add 3 to every BCD nibble >= 5, then shift
//     {bcd,bin} left by 1. Iteration counter is 4 bits; exit after BIN_W iterations.
//   DONE (1 cycle): register bcd_out, hex0..hex3, time_up<=neg_or_zero; bcd_valid=1;
//     time_up_pulse=1 iff neg_or_zero && !time_up (previous value).
// - Latency: sec high in cycle t -> bcd_valid high in cycle t+17 (sec_d t+1, CAPTURE t+2,
//   SHIFT t+3..t+16, DONE t+17). Auto-init after reset: bcd_valid 17 cycles after Reset falls.
// - sec_d arriving while busy sets pending (one level, not a queue; extra ticks merge). DONE with
//   pending clears it and goes directly to CAPTURE (fresh sample of counter_in).
// - sec_d in the same cycle as DONE counts as pending (no tick is lost).
// - time_up is level-accurate per capture: drops to 0 if a later capture is > 0 (e.g. reload).
// - 7-seg decode 0..9 standard active-low; nibble codes 10..15 never occur (decode to 7'h7F).
//   BLANK_LZ=1: a digit is blanked (7'h7F) when it and all higher digits are 0, except hex0.
// - Reset mid-conversion aborts: no bcd_valid, outputs return to reset values next cycle.
// TESTING
// 1. Reset, counter_in=120 held -> 17 cycles after Reset falls: bcd_valid=1 one cycle,
//    bcd_out=16'h0120, hex3/hex2... hex3=7'h7F (blanked), hex2=7'h79 ('1'), time_up=0.
// 2. sec at t, counter_in 60->59 at t+1 -> bcd_out=16'h0059 exactly at t+17, busy high t+2..t+17.
// 3. counter_in 1->0 on a tick -> time_up=1, time_up_pulse=1 once; next tick with
//    32'hFFFF_FFFF -> bcd_out=16'h0000, time_up stays 1, no second time_up_pulse.
// 4. counter_in=123456 -> bcd_out=16'h9999, all hex show '9' (7'h10), time_up=0.
// 5. sec at t and t+5 (value changes at t+6 to 42) -> two bcd_valid pulses (t+17, t+33),
//    second reports 16'h0042; three ticks during one conversion still yield only one extra pass.
// 6. Reset asserted at t+8 of a conversion -> next cycle all outputs at reset values, busy=0,
//    no bcd_valid until auto-init completes 17 cycles after Reset falls.

Source files
------------

// File: rtl/countdown_display_ctrl_if.sv
// Countdown-to-display bus: second tick and countdown value in, BCD/7-seg/time-up status out.
interface countdown_display_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             sec;
  logic [CNT_W-1:0] counter_in;
  logic [15:0]      bcd_out;
  logic             bcd_valid;
  logic             busy;
  logic             time_up;
  logic             time_up_pulse;
  logic [6:0]       hex0;
  logic [6:0]       hex1;
  logic [6:0]       hex2;
  logic [6:0]       hex3;

  // Countdown stage side: drives the tick and value, observes the display outputs.
  modport master (
    output sec, counter_in,
    input  bcd_out, bcd_valid, busy, time_up, time_up_pulse, hex0, hex1, hex2, hex3
  );

  // Display controller side.
  modport slave (
    input  sec, counter_in,
    output bcd_out, bcd_valid, busy, time_up, time_up_pulse, hex0, hex1, hex2, hex3
  );
endinterface

// File: rtl/countdown_display_ctrl.sv
// Samples the countdown after each second tick, clamps it to 0..MAX_VAL, converts it to
// 4-digit BCD with a sequential double-dabble, and drives active-low 7-segment digits plus
// a sticky time-up level/pulse.
module countdown_display_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned MAX_VAL  = 9999,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic                     Clk,
  input logic                     Reset,
  countdown_display_ctrl_if.slave bus
);

  localparam logic signed [CNT_W-1:0] MaxValS  = $signed(CNT_W'(MAX_VAL));
  localparam logic [3:0]              IterLast = 4'(BIN_W - 1);
  localparam logic [6:0]              SegOff   = 7'h7F;

  typedef enum logic [1:0] {StIdle, StCapture, StShift, StDone} state_e;

  state_e             state_q;
  logic               sec_d_q;
  logic               init_q;
  logic               pending_q;
  logic               neg_or_zero_q;
  logic [BIN_W-1:0]   bin_q;
  logic [15:0]        bcd_q;
  logic [3:0]         iter_q;

  logic [15:0]        bcd_out_q;
  logic               bcd_valid_q;
  logic               busy_q;
  logic               time_up_q;
  logic               time_up_pulse_q;
  logic [6:0]         hex0_q, hex1_q, hex2_q, hex3_q;

  logic signed [CNT_W-1:0] cnt_s;
  logic [BIN_W-1:0]        clamped;
  logic                    neg_or_zero;
  logic [15:0]             bcd_adj;
  logic [16+BIN_W-1:0]     dabble;
  logic [15:0]             bcd_shift;
  logic [BIN_W-1:0]        bin_shift;
  logic [6:0]              hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt;

  assign cnt_s = $signed(bus.counter_in);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegOff;
    endcase
    return s;
  endfunction

  // Clamp the signed countdown into the convertible range and flag expiry.
  always_comb begin
    clamped = '0;
    if (cnt_s[CNT_W-1]) begin
      clamped = '0;
    end else if (cnt_s > MaxValS) begin
      clamped = BIN_W'(MAX_VAL);
    end else begin
      clamped = cnt_s[BIN_W-1:0];
    end
    neg_or_zero = cnt_s[CNT_W-1] || (cnt_s == '0);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    dabble    = {bcd_adj, bin_q} << 1;
    bcd_shift = dabble[16+BIN_W-1:BIN_W];
    bin_shift = dabble[BIN_W-1:0];
  end

  // Segment decode of the final step's result, with optional leading-zero blanking.
  always_comb begin
    hex0_nxt = seg7(bcd_shift[3:0]);
    hex1_nxt = (BLANK_LZ && bcd_shift[15:4] == '0) ? SegOff : seg7(bcd_shift[7:4]);
    hex2_nxt = (BLANK_LZ && bcd_shift[15:8] == '0) ? SegOff : seg7(bcd_shift[11:8]);
    hex3_nxt = (BLANK_LZ && bcd_shift[15:12] == '0) ? SegOff : seg7(bcd_shift[15:12]);
  end

  // Conversion FSM with registered outputs; results land on entry to DONE so they are
  // visible (with bcd_valid) during the DONE cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= StIdle;
      sec_d_q         <= 1'b0;
      init_q          <= 1'b1;
      pending_q       <= 1'b0;
      neg_or_zero_q   <= 1'b0;
      bin_q           <= '0;
      bcd_q           <= '0;
      iter_q          <= '0;
      bcd_out_q       <= '0;
      bcd_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      time_up_q       <= 1'b0;
      time_up_pulse_q <= 1'b0;
      hex0_q          <= SegOff;
      hex1_q          <= SegOff;
      hex2_q          <= SegOff;
      hex3_q          <= SegOff;
    end else begin
      sec_d_q         <= bus.sec;
      init_q          <= 1'b0;
      bcd_valid_q     <= 1'b0;
      time_up_pulse_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sec_d_q || init_q) begin
            state_q <= StCapture;
            busy_q  <= 1'b1;
          end
        end
        StCapture: begin
          if (sec_d_q) pending_q <= 1'b1;
          bin_q         <= clamped;
          bcd_q         <= '0;
          neg_or_zero_q <= neg_or_zero;
          iter_q        <= '0;
          state_q       <= StShift;
        end
        StShift: begin
          if (sec_d_q) pending_q <= 1'b1;
          bin_q  <= bin_shift;
          bcd_q  <= bcd_shift;
          iter_q <= iter_q + 4'd1;
          if (iter_q == IterLast) begin
            state_q         <= StDone;
            bcd_out_q       <= bcd_shift;
            hex0_q          <= hex0_nxt;
            hex1_q          <= hex1_nxt;
            hex2_q          <= hex2_nxt;
            hex3_q          <= hex3_nxt;
            time_up_q       <= neg_or_zero_q;
            time_up_pulse_q <= neg_or_zero_q && !time_up_q;
            bcd_valid_q     <= 1'b1;
          end
        end
        StDone: begin
          // A tick landing now is merged into pending rather than lost.
          if (pending_q || sec_d_q) begin
            pending_q <= 1'b0;
            state_q   <= StCapture;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bcd_out       = bcd_out_q;
  assign bus.bcd_valid     = bcd_valid_q;
  assign bus.busy          = busy_q;
  assign bus.time_up       = time_up_q;
  assign bus.time_up_pulse = time_up_pulse_q;
  assign bus.hex0          = hex0_q;
  assign bus.hex1          = hex1_q;
  assign bus.hex2          = hex2_q;
  assign bus.hex3          = hex3_q;

endmodule
